fphub_div_issue: RTL

FPHUB_DIV_ISSUE -- requirements
Module: fphub_div_issue

---
 rtl/fphub_div_issue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fphub_div_issue.sv
// Issue stage for a HUB floating-point divider. Requests are buffered in a small FIFO
// and launched one at a time. Results, or a watchdog timeout error, are returned in request order.
module fphub_div_issue #(
  parameter int M       = 23,
  parameter int E       = 8,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M+E:0]    in_x,
  input  logic [M+E:0]    in_d,
  input  logic [TAGW-1:0] in_tag,
  output logic            div_start,
  output logic [M+E:0]    div_x,
  output logic [M+E:0]    div_d,
  input  logic [M+E:0]    div_res,
  input  logic            div_finish,
  input  logic            div_computing,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M+E:0]    out_res,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err,
  output logic            busy
);
  localparam int T  = M + E;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * (T + 1) + TAGW;
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic [T:0]      head_x, head_d;
  logic [TAGW-1:0] head_tag;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [T:0]      op_x_q, op_d_q, res_q;
  logic [TAGW-1:0] op_tag_q, tag_q;
  logic            err_q, valid_q, start_q;
  logic [7:0]      wdog_q, wdog_d;
  logic            unused_computing;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The divider's busy flag carries no information the FSM does not already track.
  assign unused_computing = div_computing;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // in_ready uses only registered state, so a same-cycle pop never frees a slot early.
  assign push = in_valid && !fifo_full;
  assign pop  = (state_q == S_IDLE) && !fifo_empty;

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_x   = head[EW-1 -: T+1];
  assign head_d   = head[TAGW +: T+1];
  assign head_tag = head[TAGW-1:0];

  assign wdog_d = sat_inc8(wdog_q);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_x, in_d, in_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_IDLE;
      op_x_q   <= '0;
      op_d_q   <= '0;
      op_tag_q <= '0;
      start_q  <= 1'b0;
      wdog_q   <= '0;
      res_q    <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            op_x_q   <= head_x;
            op_d_q   <= head_d;
            op_tag_q <= head_tag;
            start_q  <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          start_q <= 1'b0;
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (div_finish) begin
            res_q   <= div_res;
            tag_q   <= op_tag_q;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else if (wdog_d == WD_LIMIT) begin
            // Divider never answered: report a zero result flagged as an error.
            res_q   <= '0;
            tag_q   <= op_tag_q;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operands stay on the divider bus from launch through completion; the divider
  // reads them combinationally for its special cases.
  assign div_x     = op_x_q;
  assign div_d     = op_d_q;
  assign div_start = start_q;

  assign in_ready  = !fifo_full;
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE);

endmodule
